alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  [31:28] funct, [27:24] rd, [23:20] rs, [19:16] rt, [15:11] shamt, rest ignored.
- instr_ready  out  1  instruction accepted when valid&ready at clk edge.
- ld_en  in  1  external register load request.
- ld_addr  in  4  load register index.
- ld_data  in  32  load value.
- alu_a, alu_b  out  32  operands to ALU.
- alu_shamt  out  5  shift amount to ALU.
- alu_funct  out  4  ALU op (0 ADD .. 8 SRL).
- alu_res  in  32  registered ALU result, valid one cycle after issue.
- wb_valid  out  1  writeback occurring this cycle.
- wb_rd  out  4  writeback register index.
- wb_data  out  32  writeback value.
- err  out  1  one-cycle pulse on illegal funct.
- busy  out  1  high whenever state is not IDLE.
- dbg_addr  in  4, dbg_data  out  32  combinational register-file read.
REQ-002 SHALL use clock clk and reset rst_n; one clock; reset is asynchronous and active-low.

Function
REQ-003 SHALL contain a 16 x 32-bit register file, one write port, reads rs, rt, dbg_addr combinationally.
REQ-004 SHALL implement FSM states IDLE, ISSUE, WB, ERR.
REQ-005 instr_ready SHALL be 1 only in IDLE with ld_en=0.
REQ-006 In IDLE with ld_en=1: regfile[ld_addr] <= ld_data at edge; no instruction accepted that cycle.
REQ-007 On accept with funct<=8: alu_a<=R[rs], alu_b<=R[rt], alu_shamt<=shamt, alu_funct<=funct, wb_rd<=rd; IDLE->ISSUE.
REQ-008 On accept with funct 9..15: operands unchanged; IDLE->ERR; err=1 for exactly the ERR cycle; ERR->IDLE; no write.
REQ-009 ISSUE SHALL last one cycle (ALU samples at its end), then ->WB.
REQ-010 In WB: wb_valid=1, wb_data=alu_res; regfile[wb_rd]<=alu_res at end of WB; WB->IDLE.
REQ-011 Accept-to-writeback-edge latency SHALL be 2 cycles; issue interval 3 cycles minimum.
REQ-012 alu_a/alu_b/alu_shamt/alu_funct/wb_rd SHALL hold last issued values until next legal accept.
REQ-013 rs or rt equal to the previous rd SHALL read the written value (write completes before next accept).
REQ-014 ld_en outside IDLE SHALL be ignored.
REQ-015 busy = (state != IDLE).

Reset
REQ-016 rst_n low SHALL immediately force IDLE, all 16 registers 0, alu_a/alu_b 0, alu_shamt 0, alu_funct 0, wb_rd 0, wb_valid 0, err 0.
REQ-017 Reset during ISSUE or WB SHALL abort; no register write occurs.

Configuration
REQ-018 Macro ALU_ISSUE_ZERO_REG_EN defined: R0 reads 0 always; writes (load or WB) to R0 discarded, wb_valid still asserted.
REQ-019 Macro undefined: R0 is an ordinary register.

Verification
REQ-020 Load R1=5, R2=3; instr funct0 rd3 rs1 rt2 -> alu_a=5, alu_b=3 in ISSUE; WB wb_data=8; dbg R3=8.
REQ-021 R1=0x80000000; funct7 rd4 rs1 shamt4 -> R4=0xF8000000; back-to-back funct1 rd5 rs4 rt4 -> R5=0.
REQ-022 instr funct 12 -> err high exactly 1 cycle, no wb_valid, all registers unchanged, instr_ready high 2 cycles after accept.
REQ-023 rst_n low during WB of ADD to R6 -> R6=0, state IDLE, wb_valid 0 immediately.
REQ-024 Load R0=7, dbg_addr 0 -> 0 with ALU_ISSUE_ZERO_REG_EN, 7 without.
REQ-025 ld_en and instr_valid both high in IDLE -> load occurs, instr_ready 0, instruction accepted next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, load, ALU, writeback and debug signals of the issue controller
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_funct;
  logic [31:0] alu_res;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic        busy;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  modport slave (
    input  instr_valid, instr, ld_en, ld_addr, ld_data, alu_res, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_shamt, alu_funct, wb_valid, wb_rd, wb_data, err, busy, dbg_data
  );
  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data, alu_res, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_shamt, alu_funct, wb_valid, wb_rd, wb_data, err, busy, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction at a time to an external ALU and writes back its result; ALU_ISSUE_ZERO_REG_EN makes R0 a hardwired zero
module alu_issue_ctrl (
  input logic clk,
  input logic rst_n,
  alu_issue_ctrl_if.slave bus
);
`ifdef ALU_ISSUE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, WB, ERR} state_t;
  state_t state, state_nxt;
  logic [31:0] rf [16];
  logic [3:0] funct, rd, rs, rt, wr_addr;
  logic [4:0] shamt;
  logic [31:0] wr_data;
  logic accept, illegal, wr_en, unused_bits;
  assign {funct, rd, rs, rt, shamt} = bus.instr[31:11];
  assign unused_bits = ^bus.instr[10:0];
  assign accept = bus.instr_valid && bus.instr_ready;
  assign illegal = funct > 4'd8;
  function automatic logic [31:0] read_reg(input logic [3:0] a);
    return (ZERO_REG && a == 4'd0) ? 32'd0 : rf[a];
  endfunction
  // single write port: writeback owns it in WB, external loads only in IDLE
  always_comb begin
    wr_addr = state == WB ? bus.wb_rd : bus.ld_addr;
    wr_data = state == WB ? bus.alu_res : bus.ld_data;
    wr_en = (state == WB || (state == IDLE && bus.ld_en)) && !(ZERO_REG && wr_addr == 4'd0);
  end
  // register file, cleared by reset so an aborted writeback leaves nothing behind
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 16; i++) rf[i] <= '0;
    else if (wr_en) rf[wr_addr] <= wr_data;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: legal ops walk ISSUE->WB, illegal ones spend one cycle in ERR
  always_comb begin
    state_nxt = state == IDLE ? (accept ? (illegal ? ERR : ISSUE) : IDLE) : state == ISSUE ? WB : IDLE;
  end
  // operand latch: holds the last legal issue until the next one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_shamt <= '0;
      bus.alu_funct <= '0;
      bus.wb_rd <= '0;
    end else if (accept && !illegal) begin
      bus.alu_a <= read_reg(rs);
      bus.alu_b <= read_reg(rt);
      bus.alu_shamt <= shamt;
      bus.alu_funct <= funct;
      bus.wb_rd <= rd;
    end
  // state-decoded outputs and combinational debug read
  always_comb begin
    bus.instr_ready = state == IDLE && !bus.ld_en;
    bus.wb_valid = state == WB;
    bus.err = state == ERR;
    bus.busy = state != IDLE;
    bus.wb_data = bus.alu_res;
    bus.dbg_data = read_reg(bus.dbg_addr);
  end
endmodule
